md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//   Multi-cycle multiply/divide unit holding the HI/LO register pair.
//   Sits beside the ALU in the execute path: consumes the two GRF read
//   operands (rs -> SrcA, rt -> SrcB), produces HI/LO for mfhi/mflo writeback.
//   Drives Busy so the controller stalls dependent md instructions.
// PARAMETERS
//   MULT_CYCLES  5   cycles Busy is high for mult/multu (>=1)
//   DIV_CYCLES   10  cycles Busy is high for div/divu (>=1)
// PORTS
//   clk     in   1   system clock, rising edge
//   reset   in   1   asynchronous, active-high; clears all state
//   Start   in   1   issue strobe, qualifies MDOp for one cycle
//   MDOp    in   3   operation code (see package)
//   SrcA    in   32  rs operand
//   SrcB    in   32  rt operand
//   Busy    out  1   1 while a mult/div is in flight
//   HI      out  32  HI register, registered output
//   LO      out  32  LO register, registered output
// BEHAVIOUR
//   - Reset: HI=0, LO=0, Busy=0, counter=0, latched operands=0.
//     Async: takes effect immediately, including mid-operation; the
//     in-flight result is discarded.
//   - Issue is accepted only at a rising edge with Start=1 and Busy=0.
//     Start while Busy=1 is ignored entirely; HI/LO and the counter are
//     unchanged. The controller must stall and never rely on this.
//   - MULT/MULTU/DIV/DIVU accepted at edge T0:
//     - SrcA/SrcB and MDOp are latched.
//     - Counter is loaded with MULT_CYCLES or DIV_CYCLES.
//     - Busy=1 from T0 onward.
//   - Counter decrements on every edge while nonzero. At the edge where it
//     goes from 1 to 0, HI/LO take the result and Busy falls at that same
//     edge. Busy is high for exactly N cycles; new HI/LO are visible the
//     cycle Busy is first 0.
//   - Result arithmetic:
//     - mult: signed 32x32 -> 64. multu: unsigned. {HI,LO} = product.
//     - div: signed. LO = quotient truncated toward zero; HI = remainder
//       with the sign of the dividend.
//     - divu: unsigned quotient (LO) and remainder (HI).
//     - Divisor 0 (div or divu): full latency, HI and LO left unchanged.
//     - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
//   - MTHI/MTLO accepted at edge:
//     - HI (resp. LO) = SrcA at that same edge.
//     - Busy stays 0; no latency.
//   - MD_NONE with Start=1: no effect.
//   - Operands are sampled only at issue; SrcA/SrcB changes while Busy=1
//     do not affect the result.
//   - Reading (mfhi/mflo) is combinational on HI/LO outside this block.
//     The controller stalls mfhi/mflo while Busy=1, and also while
//     Start=1 with a mult/div op.
// STRUCTURE
//   - Shared package md_defs: MDOp localparams
//     MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5,
//     MD_MTLO=6. The controller's MDOp decode uses the same constants.
//   - Result computed combinationally from latched operands, using
//     $signed for signed ops; only the counter models latency.
//   - No sub-module needed. Counter width is
//     $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
// TESTING
//   1. mult SrcA=3, SrcB=0xFFFFFFFE -> Busy high 5 cycles, then
//      HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//   2. divu 7/2 -> Busy high 10 cycles, then LO=3, HI=1.
//      div 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   3. mthi 0x12345678 then mtlo 0x9 on consecutive edges -> HI=0x12345678,
//      LO=9 immediately; Busy stays 0. Follow with div x/0 -> after 10
//      cycles HI/LO are still 0x12345678/9.
//   4. multu 0xFFFFFFFF*0xFFFFFFFF, with Start+div 1/1 issued on cycle 2
//      of Busy -> ignored; HI=0xFFFFFFFE, LO=1 after 5 cycles.
//   5. Assert reset on cycle 4 of a div -> HI=LO=0 and Busy=0 immediately,
//      with no later update. Also check div 0x80000000/0xFFFFFFFF ->
//      LO=0x80000000, HI=0.

Source files
------------

// File: rtl/md_defs.sv
// Shared MDOp encoding and helpers for the multiply/divide unit.
// The controller's MDOp decode imports the same constants.
package md_defs;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair.
// Result is computed combinationally from latched operands; a down-counter models latency.
module md_unit
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned CntW = $clog2(max_u(MULT_CYCLES, DIV_CYCLES) + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, uq, ur;
  md_res_t     res;

  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes: keeps 0x80000000 / -1 well defined (no overflow trap).
  assign mag_a = a_q[31] ? (32'd0 - a_q) : a_q;
  assign mag_b = b_q[31] ? (32'd0 - b_q) : b_q;
  assign uq    = mag_a / mag_b;
  assign ur    = mag_a % mag_b;

  always_comb begin
    res    = '0;
    res.hi = hi_q;
    res.lo = lo_q;
    case (op_q)
      MD_MULT: begin
        res.wr = 1'b1;
        res.hi = prod_s[63:32];
        res.lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res.wr = 1'b1;
        res.hi = prod_u[63:32];
        res.lo = prod_u[31:0];
      end
      MD_DIV: begin
        res.wr = (b_q != 32'd0);
        res.lo = (a_q[31] ^ b_q[31]) ? (32'd0 - uq) : uq;
        res.hi = a_q[31] ? (32'd0 - ur) : ur;
      end
      MD_DIVU: begin
        res.wr = (b_q != 32'd0);
        res.lo = a_q / b_q;
        res.hi = a_q % b_q;
      end
      default: ;
    endcase
  end

  assign Busy = (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (Busy) begin
      // Start while busy is dropped on the floor.
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1) && res.wr) begin
        hi_d = res.hi;
        lo_d = res.lo;
      end
    end else if (Start) begin
      case (MDOp)
        MD_MULT, MD_MULTU: begin
          op_d  = MDOp;
          a_d   = SrcA;
          b_d   = SrcB;
          cnt_d = CntW'(MULT_CYCLES);
        end
        MD_DIV, MD_DIVU: begin
          op_d  = MDOp;
          a_d   = SrcA;
          b_d   = SrcB;
          cnt_d = CntW'(DIV_CYCLES);
        end
        MD_MTHI: hi_d = SrcA;
        MD_MTLO: lo_d = SrcA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= MD_NONE;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO/latency pushed at issue, popped when Busy drops.
module tb_md_unit;
  import md_defs::*;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] SrcA, SrcB;
  logic        Busy;
  logic [31:0] HI, LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  md_unit #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one Start cycle; operands are scrambled right after to prove they were latched.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1;
    MDOp  = op;
    SrcA  = a;
    SrcB  = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
    MDOp  = MD_NONE;
    SrcA  = $urandom;
    SrcB  = $urandom;
  endtask

  task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int lat);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Called #1 after an edge with Busy expected high; pre = cycles already counted.
  task automatic wait_done(input string tag, input int pre);
    int   n;
    exp_t e;
    n = pre;
    while (Busy && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_busy_len"}, 64'(n), 64'(e.lat));
      check({tag, "_hi"}, {32'd0, HI}, {32'd0, e.hi});
      check({tag, "_lo"}, {32'd0, LO}, {32'd0, e.lo});
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    push(hi, lo, ((op == MD_MULT) || (op == MD_MULTU)) ? int'(MultN) : int'(DivN));
    issue(op, a, b);
    wait_done(tag, 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] rp;

    reset = 1'b1;
    Start = 1'b0;
    MDOp  = MD_NONE;
    SrcA  = '0;
    SrcB  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_hilo", {HI, LO}, 64'd0);
    reset = 1'b0;

    // MD_NONE with Start does nothing.
    issue(MD_NONE, 32'h1111_1111, 32'h2222_2222);
    check("none_busy", {63'd0, Busy}, 64'd0);
    check("none_hilo", {HI, LO}, 64'd0);

    run_op("mult", MD_MULT, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("divu", MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(MD_MTHI, 32'h1234_5678, 32'd0);
    check("mthi_hi", {32'd0, HI}, 64'h1234_5678);
    check("mthi_busy", {63'd0, Busy}, 64'd0);
    issue(MD_MTLO, 32'd9, 32'd0);
    check("mtlo_hilo", {HI, LO}, 64'h1234_5678_0000_0009);
    check("mtlo_busy", {63'd0, Busy}, 64'd0);

    run_op("div0", MD_DIV, 32'd77, 32'd0, 32'h1234_5678, 32'd9);
    run_op("divu0", MD_DIVU, 32'd5, 32'd0, 32'h1234_5678, 32'd9);

    // multu with an ignored div 1/1 issued on the second busy cycle.
    push(32'hFFFF_FFFE, 32'd1, MultN);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(MD_DIV, 32'd1, 32'd1);
    wait_done("multu_ign", 1);
    repeat (DivN + 2) @(posedge clk);
    #1;
    check("ign_busy", {63'd0, Busy}, 64'd0);
    check("ign_hilo", {HI, LO}, 64'hFFFF_FFFE_0000_0001);

    // Reset in cycle 4 of a div: cleared at once, no late write-back.
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {63'd0, Busy}, 64'd0);
    check("mid_rst_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (DivN + 2) @(posedge clk);
    #1;
    check("post_rst_busy", {63'd0, Busy}, 64'd0);
    check("post_rst_hilo", {HI, LO}, 64'd0);

    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("div_mix", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      rp = {32'd0, ra} * {32'd0, rb};
      run_op("multu_rnd", MD_MULTU, ra, rb, rp[63:32], rp[31:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
